ulaplus_pal_sched: RTL and testbench

//  Time-multiplexes the single-port 64x8 ULAplus palette RAM between video fetch (ink, paper),

---
 rtl/ulaplus_pal_sched_if.sv | 34 +++
 rtl/ulaplus_pal_sched.sv | 161 ++++++++++++++++
 tb/tb_ulaplus_pal_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ulaplus_pal_sched_if.sv
// rtl/ulaplus_pal_sched_if.sv - port-decode, video and palette-RAM signals of the palette scheduler
`timescale 1ns/1ps

interface ulaplus_pal_sched_if;
    logic       en;
    logic       wr_req;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_full;
    logic       overflow;
    logic       rd_req;
    logic [5:0] rd_addr;
    logic       rd_busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [5:0] ink_addr;
    logic [5:0] paper_addr;
    logic [7:0] ink;
    logic [7:0] paper;
    logic [5:0] ram_a;
    logic [7:0] ram_d;
    logic       ram_we;
    logic [7:0] ram_q;

    modport slave (
        input  en, wr_req, wr_addr, wr_data, rd_req, rd_addr, ink_addr, paper_addr, ram_q,
        output wr_full, overflow, rd_busy, rd_data, rd_valid, ink, paper, ram_a, ram_d, ram_we
    );

    modport master (
        output en, wr_req, wr_addr, wr_data, rd_req, rd_addr, ink_addr, paper_addr, ram_q,
        input  wr_full, overflow, rd_busy, rd_data, rd_valid, ink, paper, ram_a, ram_d, ram_we
    );
endinterface

// File: rtl/ulaplus_pal_sched.sv
// rtl/ulaplus_pal_sched.sv - ULAplus palette RAM slot scheduler; read-back path under ULAPLUS_READBACK_EN
`timescale 1ns/1ps

module ulaplus_pal_sched #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk28,
    input  logic                 rst_n,
    ulaplus_pal_sched_if.slave   bus
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]    slot_q, slot_d;
    logic [13:0]   fifo_q [FIFO_DEPTH];
    logic [13:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    ink_q, ink_d, paper_q, paper_d;

    logic          cpu_slot, fifo_full, pop, push, push_req, rd_sel;
    logic [13:0]   head;

    assign cpu_slot  = slot_q[1];
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign pop       = bus.en && cpu_slot && (count_q != '0);
    assign head      = fifo_q[rptr_q];
    assign push_req  = bus.en && bus.wr_req;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push      = push_req && (!fifo_full || pop);

`ifdef ULAPLUS_READBACK_EN
    typedef enum logic [1:0] {RD_IDLE, RD_PEND, RD_FLY} rd_state_t;

    rd_state_t  rd_state_q, rd_state_d;
    logic [5:0] rd_addr_q, rd_addr_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;

    assign rd_sel = (rd_state_q == RD_PEND);

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (!bus.en) begin
            rd_state_d = RD_IDLE;
        end else begin
            case (rd_state_q)
                RD_IDLE: if (bus.rd_req) begin
                    rd_addr_d  = bus.rd_addr;
                    rd_state_d = RD_PEND;
                end
                RD_PEND: if (cpu_slot && !pop) rd_state_d = RD_FLY;
                RD_FLY: begin
                    rd_data_d  = bus.ram_q;
                    rd_valid_d = 1'b1;
                    rd_state_d = RD_IDLE;
                end
                default: rd_state_d = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_busy  = (rd_state_q != RD_IDLE);
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    logic       unused_rd;
    logic [5:0] rd_addr_q;

    assign unused_rd    = ^{bus.rd_req, bus.rd_addr};
    assign rd_sel       = 1'b0;
    assign rd_addr_q    = '0;
    assign bus.rd_busy  = 1'b0;
    assign bus.rd_data  = '0;
    assign bus.rd_valid = 1'b0;
`endif

    always_comb begin
        slot_d     = slot_q + 2'd1;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        // ram_q carries the previous slot's read, so each colour lands one slot late.
        ink_d      = (slot_q == 2'd1) ? bus.ram_q : ink_q;
        paper_d    = (slot_q == 2'd2) ? bus.ram_q : paper_q;
        if (!bus.en) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                fifo_d[wptr_q] = {bus.wr_addr, bus.wr_data};
                wptr_d         = wptr_q + PW'(1);
            end
            if (push_req && !push) overflow_d = 1'b1;
            if (pop) rptr_d = rptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ink_q      <= '0;
            paper_q    <= '0;
        end else begin
            slot_q     <= slot_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ink_q      <= ink_d;
            paper_q    <= paper_d;
        end
    end

    // Idle CPU slots re-read paper so the RAM address never floats.
    always_comb begin
        case (slot_q)
            2'd0:    bus.ram_a = bus.ink_addr;
            2'd1:    bus.ram_a = bus.paper_addr;
            default: bus.ram_a = pop ? head[13:8] : (rd_sel ? rd_addr_q : bus.paper_addr);
        endcase
    end

    assign bus.ram_d    = pop ? head[7:0] : 8'h00;
    assign bus.ram_we   = pop;
    assign bus.wr_full  = fifo_full;
    assign bus.overflow = overflow_q;
    assign bus.ink      = ink_q;
    assign bus.paper    = paper_q;

endmodule

// File: tb/tb_ulaplus_pal_sched.sv
// tb/tb_ulaplus_pal_sched.sv - scoreboard bench for ulaplus_pal_sched with a palette RAM model
`timescale 1ns/1ps

module tb_ulaplus_pal_sched;
    localparam int FD = 4;

    logic clk28 = 1'b0;
    logic rst_n;
    always #5 clk28 = ~clk28;

    ulaplus_pal_sched_if bus();

    ulaplus_pal_sched #(.FIFO_DEPTH(FD)) dut (
        .clk28 (clk28),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [1:0]  tslot;
    logic [13:0] wq[$];
    logic [7:0]  rq[$];
    logic [7:0]  ram [64];
    logic        pre_we;
    logic [5:0]  pre_a;
    logic [7:0]  pre_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic wait_slot(input logic [1:0] s);
        for (int i = 0; i < 4 && tslot != s; i++) tick();
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_req  = 1'b0;
    endtask

    // Reference slot counter, independent of the DUT
    always @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) tslot <= 2'd0;
        else        tslot <= tslot + 2'd1;
    end

    always @(posedge clk28) begin
        if (pre_we)          ram[pre_a]     <= pre_d;
        else if (bus.ram_we) ram[bus.ram_a] <= bus.ram_d;
        bus.ram_q <= ram[bus.ram_a];
    end

    always @(negedge clk28) begin
        logic [13:0] e;
        if (rst_n === 1'b1) begin
            if (tslot == 2'd0) check("slot0_ink_addr", 32'(bus.ram_a), 32'(bus.ink_addr));
            if (tslot == 2'd1) check("slot1_paper_addr", 32'(bus.ram_a), 32'(bus.paper_addr));
            if (bus.ram_we !== 1'b0) begin
                check("we_in_cpu_slot", 32'(tslot[1]), 32'd1);
                if (wq.size() == 0) begin
                    check("unexpected_we", 32'(bus.ram_we), 32'd0);
                end else begin
                    e = wq.pop_front();
                    check("we_addr", 32'(bus.ram_a), 32'(e[13:8]));
                    check("we_data", 32'(bus.ram_d), 32'(e[7:0]));
                end
            end
            if (bus.rd_valid !== 1'b0) begin
                check("rd_busy_with_valid", 32'(bus.rd_busy), 32'd0);
                if (rq.size() == 0) check("unexpected_rd_valid", 32'(bus.rd_valid), 32'd0);
                else                check("rd_data", 32'(bus.rd_data), 32'(rq.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.wr_req     = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        bus.ink_addr   = 6'd5;
        bus.paper_addr = 6'd9;
        pre_we         = 1'b0;
        pre_a          = '0;
        pre_d          = '0;
        #2;
        check("rst_ink", 32'(bus.ink), 32'h0);
        check("rst_paper", 32'(bus.paper), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("rst_wr_full", 32'(bus.wr_full), 32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);
        check("rst_rd_busy", 32'(bus.rd_busy), 32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_ram_we", 32'(bus.ram_we), 32'h0);

        pre_we = 1'b1; pre_a = 6'd5; pre_d = 8'hE0; tick();
        pre_a = 6'd9; pre_d = 8'h1C; tick();
        pre_a = 6'd7; pre_d = 8'h11; tick();
        pre_we = 1'b0; tick();
        rst_n = 1'b1;

        // Video fetch only
        repeat (8) tick();
        check("video_ink", 32'(bus.ink), 32'hE0);
        check("video_paper", 32'(bus.paper), 32'h1C);

        // Single write lands in slot 2 and shows up as ink
        wait_slot(2'd0);
        wq.push_back({6'd5, 8'h03});
        wr(6'd5, 8'h03);
        check("w1_slot1_we", 32'(bus.ram_we), 32'd0);
        tick();
        check("w1_slot2_we", 32'(bus.ram_we), 32'd1);
        check("w1_slot2_a", 32'(bus.ram_a), 32'd5);
        repeat (8) tick();
        check("w1_ink", 32'(bus.ink), 32'h03);

        // Continuous writes: fill, accept-while-full-with-pop, then drop
        wait_slot(2'd0);
        for (int i = 0; i < 9; i++) begin
            if (i == 6) check("fill_full", 32'(bus.wr_full), 32'd1);
            if (i == 8) check("fill_no_ovf_yet", 32'(bus.overflow), 32'd0);
            bus.wr_req  = 1'b1;
            bus.wr_addr = 6'(16 + i);
            bus.wr_data = 8'(8'h40 + i);
            if (i != 8) wq.push_back({6'(16 + i), 8'(8'h40 + i)});
            tick();
        end
        bus.wr_req = 1'b0;
        check("drop_overflow", 32'(bus.overflow), 32'd1);
        check("drop_full", 32'(bus.wr_full), 32'd1);
        tick();
        tick();
        check("drain_not_full", 32'(bus.wr_full), 32'd0);
        repeat (6) tick();
        check("drain_done", 32'(wq.size()), 32'd0);
        check("overflow_sticky", 32'(bus.overflow), 32'd1);

        // Read after write to the same entry; second rd_req while busy is ignored
        wait_slot(2'd0);
        wq.push_back({6'd7, 8'hAA});
`ifdef ULAPLUS_READBACK_EN
        rq.push_back(8'hAA);
`endif
        wr(6'd7, 8'hAA);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 6'd7;
        tick();
        bus.rd_addr = 6'd9;
`ifdef ULAPLUS_READBACK_EN
        check("rd_busy_set", 32'(bus.rd_busy), 32'd1);
`else
        check("rd_busy_off", 32'(bus.rd_busy), 32'd0);
`endif
        tick();
        bus.rd_req = 1'b0;
        for (int i = 0; i < 4 * (FD / 2) + 8 && (rq.size() != 0 || wq.size() != 0); i++) tick();
        check("rd_done", 32'(rq.size()), 32'd0);
        check("rd_busy_idle", 32'(bus.rd_busy), 32'd0);
`ifdef ULAPLUS_READBACK_EN
        check("rd_data_hold", 32'(bus.rd_data), 32'hAA);
`else
        check("rd_data_off", 32'(bus.rd_data), 32'h00);
`endif

        // en low for one cycle flushes the FIFO and cancels the read
        wait_slot(2'd0);
        wr(6'd20, 8'h55);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 6'd5;
        tick();
        bus.rd_req = 1'b0;
`ifdef ULAPLUS_READBACK_EN
        check("en0_rd_pending", 32'(bus.rd_busy), 32'd1);
`endif
        bus.en      = 1'b0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 6'd21;
        bus.wr_data = 8'h77;
        #1;
        check("en0_no_we", 32'(bus.ram_we), 32'd0);
        tick();
        bus.en     = 1'b1;
        bus.wr_req = 1'b0;
        check("en0_rd_busy", 32'(bus.rd_busy), 32'd0);
        check("en0_not_full", 32'(bus.wr_full), 32'd0);
        check("en0_overflow_kept", 32'(bus.overflow), 32'd1);
        repeat (12) tick();

        // Asynchronous reset with writes pending
        wait_slot(2'd0);
        wr(6'd24, 8'h66);
        wr(6'd25, 8'h67);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_ram_we", 32'(bus.ram_we), 32'd0);
        check("arst_ink", 32'(bus.ink), 32'h0);
        check("arst_paper", 32'(bus.paper), 32'h0);
        check("arst_overflow", 32'(bus.overflow), 32'd0);
        check("arst_rd_busy", 32'(bus.rd_busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("arst_ink_refetch", 32'(bus.ink), 32'h03);
        check("final_wq_empty", 32'(wq.size()), 32'd0);
        check("final_rq_empty", 32'(rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
